// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count controller: FSM state encoding and
// the data width of the downstream 4-bit counter.
package count_ctrl_pkg;

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLoad,
        StDone
    } state_e;

endpackage

// File: rtl/count_ctrl_if.sv
// Control/handshake bundle between a host and the count controller,
// including the downstream counter strobes and status.
interface count_ctrl_if
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned WRAP_W = 4
);

    logic              start;
    logic              stop;
    logic [DIV_W-1:0]  div;
    logic [WRAP_W-1:0] wrap_limit;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CntW-1:0]   cmd_data;
    logic              wrap_in;
    logic              cnt_enable;
    logic              cnt_load;
    logic [CntW-1:0]   cnt_data;
    logic              busy;
    logic              done;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output start, stop, div, wrap_limit, cmd_valid, cmd_data, wrap_in,
        input  cmd_ready, cnt_enable, cnt_load, cnt_data, busy, done, wrap_count
    );

    modport slave (
        input  start, stop, div, wrap_limit, cmd_valid, cmd_data, wrap_in,
        output cmd_ready, cnt_enable, cnt_load, cnt_data, busy, done, wrap_count
    );

endinterface

// File: rtl/count_prescaler.sv
// Tick prescaler: counts 0..div while not held and flags the terminal
// count; clr restarts the phase at zero.
module count_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = !hold && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Count controller: paces a downstream 4-bit counter with prescaled
// enables, forwards preload commands and ends a run after N wraps.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned WRAP_W = 4
) (
    input logic         clk,
    input logic         rst,
    count_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic              from_run_q, from_run_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [WRAP_W-1:0] limit_q, limit_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic [CntW-1:0]   cnt_data_q, cnt_data_d;
    logic              cnt_enable_q, cnt_enable_d;
    logic              cnt_load_q, cnt_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic in_run, cmd_ready, xfer, wrap_done, run_go, tick;

    assign in_run    = (state_q == StRun);
    assign cmd_ready = ((state_q == StIdle) || in_run) && !bus.stop;
    assign xfer      = bus.cmd_valid && cmd_ready;
    // Truncating add: a saturated count never matches a nonzero limit.
    assign wrap_done = in_run && bus.wrap_in && (limit_q != '0) &&
                       ((wrap_count_q + WRAP_W'(1)) == limit_q);
    assign run_go    = (state_q == StIdle) && (state_d == StRun);

    count_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_go),
        .hold (!in_run),
        .div  (div_q),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        from_run_d = from_run_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d    = StLoad;
                    from_run_d = 1'b0;
                end else if (bus.start && !bus.stop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    state_d    = StLoad;
                    from_run_d = 1'b1;
                end else if (wrap_done) begin
                    state_d = StDone;
                end
            end
            StLoad: begin
                state_d = (bus.stop || !from_run_q) ? StIdle : StRun;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            from_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            from_run_q <= from_run_d;
        end
    end

    // Output registers are fed from the next state so they line up with it.
    always_comb begin
        div_d        = div_q;
        limit_d      = limit_q;
        wrap_count_d = wrap_count_q;
        cnt_data_d   = cnt_data_q;
        if (run_go) begin
            div_d        = bus.div;
            limit_d      = bus.wrap_limit;
            wrap_count_d = '0;
        end else if (in_run && bus.wrap_in && (wrap_count_q != '1)) begin
            wrap_count_d = wrap_count_q + WRAP_W'(1);
        end
        if (xfer) begin
            cnt_data_d = bus.cmd_data;
        end
        cnt_enable_d = in_run && tick && !bus.stop && !xfer && !wrap_done;
        cnt_load_d   = (state_d == StLoad);
        busy_d       = (state_d == StRun) || ((state_d == StLoad) && from_run_d);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            limit_q      <= '0;
            wrap_count_q <= '0;
            cnt_data_q   <= '0;
            cnt_enable_q <= 1'b0;
            cnt_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            div_q        <= div_d;
            limit_q      <= limit_d;
            wrap_count_q <= wrap_count_d;
            cnt_data_q   <= cnt_data_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_load_q   <= cnt_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.cnt_enable = cnt_enable_q;
    assign bus.cnt_load   = cnt_load_q;
    assign bus.cnt_data   = cnt_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wrap_count = wrap_count_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: a per-cycle vector table plus short
// sequences for div=0, stop during LOAD, saturation and async reset.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned WRAP_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    count_ctrl_if #(.DIV_W(DIV_W), .WRAP_W(WRAP_W)) bus ();

    count_ctrl #(
        .DIV_W  (DIV_W),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       st;
        logic       sp;
        logic       cv;
        logic [3:0] cd;
        logic       wi;
        logic       rdy;
        logic       en;
        logic       ld;
        logic [3:0] data;
        logic       busy;
        logic       done;
        logic [3:0] wc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic cv, input logic [3:0] cd,
                       input logic wi, input logic rdy, input logic en, input logic ld,
                       input logic [3:0] data, input logic busy, input logic done,
                       input logic [3:0] wc);
        vec_t v;
        v.st = st; v.sp = sp; v.cv = cv; v.cd = cd; v.wi = wi; v.rdy = rdy;
        v.en = en; v.ld = ld; v.data = data; v.busy = busy; v.done = done; v.wc = wc;
        vq.push_back(v);
    endtask

    task automatic drive(input logic st, input logic sp, input logic cv, input logic [3:0] cd,
                         input logic wi);
        @(negedge clk);
        bus.start     = st;
        bus.stop      = sp;
        bus.cmd_valid = cv;
        bus.cmd_data  = cd;
        bus.wrap_in   = wi;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic en, input logic ld,
                              input logic [3:0] data, input logic busy, input logic done,
                              input logic [3:0] wc);
        chk({tag, ".cnt_enable"}, 32'(bus.cnt_enable), 32'(en));
        chk({tag, ".cnt_load"},   32'(bus.cnt_load),   32'(ld));
        chk({tag, ".cnt_data"},   32'(bus.cnt_data),   32'(data));
        chk({tag, ".busy"},       32'(bus.busy),       32'(busy));
        chk({tag, ".done"},       32'(bus.done),       32'(done));
        chk({tag, ".wrap_count"}, 32'(bus.wrap_count), 32'(wc));
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.div        = 8'd3;
        bus.wrap_limit = 4'd2;
        bus.cmd_valid  = 1'b0;
        bus.cmd_data   = 4'h0;
        bus.wrap_in    = 1'b0;

        // rows: start stop cmd_valid cmd_data wrap_in | ready | en ld data busy done wc
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 0, 0, 0);  // idle
        add(1, 1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0);  // start+stop: stay idle
        add(1, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 0, 0);  // enter RUN (cycle 0)
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 0, 0);  // cycle 1
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 0, 0);  // cycle 2
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 0, 0);  // cycle 3
        add(0, 0, 0, 4'h0, 0, 1, 1, 0, 4'h0, 1, 0, 0);  // cycle 4: enable
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 0, 0);  // cycle 5
        add(0, 0, 1, 4'hA, 0, 1, 0, 1, 4'hA, 1, 0, 0);  // preload A -> LOAD
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 4'hA, 1, 0, 0);  // LOAD -> RUN
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'hA, 1, 0, 0);  // would have been the cycle-8 enable
        add(0, 0, 0, 4'h0, 0, 1, 1, 0, 4'hA, 1, 0, 0);  // enable one cycle late
        add(0, 0, 0, 4'h0, 1, 1, 0, 0, 4'hA, 1, 0, 1);  // first wrap
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'hA, 1, 0, 1);
        add(0, 0, 0, 4'h0, 1, 1, 0, 0, 4'hA, 0, 1, 2);  // second wrap -> DONE
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 4'hA, 0, 0, 2);  // DONE -> IDLE, count held
        add(0, 0, 0, 4'h0, 1, 1, 0, 0, 4'hA, 0, 0, 2);  // wrap ignored in IDLE
        add(1, 0, 0, 4'h0, 0, 1, 0, 0, 4'hA, 1, 0, 0);  // restart clears count
        add(0, 1, 1, 4'h5, 0, 0, 0, 0, 4'hA, 0, 0, 0);  // stop beats cmd
        add(0, 0, 0, 4'h0, 0, 1, 0, 0, 4'hA, 0, 0, 0);
        add(0, 0, 1, 4'h3, 0, 1, 0, 1, 4'h3, 0, 0, 0);  // preload from IDLE
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 4'h3, 0, 0, 0);  // LOAD -> IDLE
        add(1, 0, 0, 4'h0, 0, 1, 0, 0, 4'h3, 1, 0, 0);  // RUN again

        #12;
        check_outs("reset", 0, 0, 4'h0, 0, 0, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].st, vq[i].sp, vq[i].cv, vq[i].cd, vq[i].wi);
            chk($sformatf("v%0d.cmd_ready", i), 32'(bus.cmd_ready), 32'(vq[i].rdy));
            step_edge();
            check_outs($sformatf("v%0d", i), vq[i].en, vq[i].ld, vq[i].data, vq[i].busy,
                       vq[i].done, vq[i].wc);
        end

        // div=0: enable on every RUN cycle after the first
        drive(0, 1, 0, 4'h0, 0);
        step_edge();
        chk("div0.stopped_busy", 32'(bus.busy), 32'd0);
        bus.div        = 8'd0;
        bus.wrap_limit = 4'd0;
        drive(1, 0, 0, 4'h0, 0);
        step_edge();
        chk("div0.first_en", 32'(bus.cnt_enable), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 4'h0, 0);
            step_edge();
            chk($sformatf("div0.en%0d", k), 32'(bus.cnt_enable), 32'd1);
        end
        drive(0, 1, 0, 4'h0, 0);
        step_edge();
        chk("div0.stop_en", 32'(bus.cnt_enable), 32'd0);
        chk("div0.stop_busy", 32'(bus.busy), 32'd0);
        chk("div0.stop_done", 32'(bus.done), 32'd0);

        // stop while in LOAD from RUN: load completes, then IDLE
        bus.div = 8'd3;
        drive(1, 0, 0, 4'h0, 0);
        step_edge();
        drive(0, 0, 1, 4'h7, 0);
        step_edge();
        check_outs("ldstop.load", 0, 1, 4'h7, 1, 0, 4'h0);
        drive(0, 1, 0, 4'h0, 0);
        step_edge();
        check_outs("ldstop.idle", 0, 0, 4'h7, 0, 0, 4'h0);
        drive(0, 0, 0, 4'h0, 0);
        chk("ldstop.ready", 32'(bus.cmd_ready), 32'd1);

        // unlimited run: wrap_count saturates at all-ones
        drive(1, 0, 0, 4'h0, 0);
        step_edge();
        for (int k = 0; k < 17; k++) begin
            drive(0, 0, 0, 4'h0, 1);
            step_edge();
        end
        chk("sat.wrap_count", 32'(bus.wrap_count), 32'd15);
        chk("sat.busy", 32'(bus.busy), 32'd1);
        chk("sat.done", 32'(bus.done), 32'd0);
        drive(0, 1, 0, 4'h0, 0);
        step_edge();

        // async reset mid-RUN with wrap_count=3
        drive(1, 0, 0, 4'h0, 0);
        step_edge();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 4'h0, 1);
            step_edge();
        end
        drive(0, 0, 0, 4'h0, 0);
        chk("rstmid.pre_wc", 32'(bus.wrap_count), 32'd3);
        chk("rstmid.pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_outs("rstmid.async", 0, 0, 4'h0, 0, 0, 4'h0);
        step_edge();
        @(negedge clk);
        rst = 1'b0;
        step_edge();
        check_outs("rstmid.after", 0, 0, 4'h0, 0, 0, 4'h0);
        drive(0, 0, 0, 4'h0, 0);
        chk("rstmid.idle_ready", 32'(bus.cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter: DIV_W, 8, prescaler divider width.
REQ-002 Parameter: WRAP_W, 4, wrap-limit and wrap-count width.
REQ-003 Reset rst, asynchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  run request, sampled per cycle.
REQ-007 stop  input  1  abort request, sampled per cycle.
REQ-008 div  input  DIV_W  tick period minus one; sampled when start is accepted.
REQ-009 wrap_limit  input  WRAP_W  wraps before completion; 0 = unlimited; sampled when start is accepted.
REQ-010 cmd_valid  input  1  preload command valid.
REQ-011 cmd_ready  output  1  preload command ready.
REQ-012 cmd_data  input  4  preload value.
REQ-013 wrap_in  input  1  one-cycle wrap pulse from the downstream 4-bit counter.
REQ-014 cnt_enable  output  1  count-enable pulse to the downstream counter.
REQ-015 cnt_load  output  1  load strobe to the downstream counter.
REQ-016 cnt_data  output  4  load value to the downstream counter.
REQ-017 busy  output  1  high in RUN and LOAD-from-RUN.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 wrap_count  output  WRAP_W  wraps seen in the current run.

Function
REQ-020 FSM states SHALL be IDLE, RUN, LOAD and DONE; all outputs except cmd_ready SHALL be registered.
REQ-021 Event priority per cycle SHALL be: stop > cmd transfer > wrap completion > tick.
REQ-022 IDLE: start=1 with stop=0 -> RUN; latch div and wrap_limit; clear prescaler and wrap_count.
REQ-023 IDLE: start=1 with stop=1 -> remain in IDLE.
REQ-024 cmd_ready SHALL equal (state==IDLE or state==RUN) and not stop; a transfer occurs when cmd_valid and cmd_ready are both high.
REQ-025 Transfer -> LOAD for exactly one cycle; cnt_load=1 and cnt_data=cmd_data latched at transfer; then return to the originating state (IDLE or RUN).
REQ-026 cnt_data SHALL hold its last loaded value outside LOAD.
REQ-027 RUN: prescaler SHALL count 0..div; at prescaler==div, cnt_enable=1 for one cycle and prescaler -> 0.
REQ-028 div=0 SHALL give cnt_enable=1 on every RUN cycle.
REQ-029 First cnt_enable SHALL assert div+1 cycles after entry to RUN.
REQ-030 cnt_enable and cnt_load SHALL never be high together; the prescaler SHALL hold through LOAD.
REQ-031 wrap_in in RUN SHALL increment wrap_count, saturating at all-ones; wrap_in outside RUN SHALL be ignored.
REQ-032 wrap_limit!=0 and wrap_count+1==wrap_limit on wrap_in -> DONE; no cnt_enable in that cycle.
REQ-033 DONE: done=1 for one cycle, then IDLE; wrap_count SHALL hold until the next accepted start.
REQ-034 stop in RUN or LOAD -> IDLE next cycle; cnt_enable=0, no done pulse, an in-flight cnt_load completes.
REQ-035 start while in RUN, LOAD or DONE SHALL be ignored.

Reset
REQ-036 rst SHALL force IDLE immediately, independent of clk.
REQ-037 rst SHALL clear cnt_enable, cnt_load, done and busy, set cnt_data=4'h0 and wrap_count=0, and clear the prescaler and latched div/wrap_limit.
REQ-038 rst asserted mid-RUN or mid-LOAD SHALL abort with no done pulse; the first cycle after release SHALL be IDLE.

Structure
REQ-039 The FSM state enum and the 4-bit counter data width constant SHALL live in the shared counter package.
REQ-040 The prescaler SHALL be one sub-module, count_prescaler (inputs clr, hold, div; output tick).

Verification
REQ-041 div=3, wrap_limit=0, start pulse -> cnt_enable high on cycles 4, 8, 12 after RUN entry, low otherwise.
REQ-042 wrap_limit=2, two wrap_in pulses in RUN -> wrap_count=2, done for one cycle, IDLE next, busy low.
REQ-043 cmd_valid with cmd_data=4'hA in RUN -> one-cycle cnt_load, cnt_data=4'hA, no cnt_enable that cycle, tick phase delayed by one cycle.
REQ-044 stop and cmd_valid in the same RUN cycle -> cmd_ready=0, no transfer, IDLE next, done never asserted.
REQ-045 start and stop together in IDLE -> remain IDLE, cnt_enable stays 0.
REQ-046 rst asserted mid-RUN with wrap_count=3 -> all outputs at reset values before the next clk edge; IDLE after release.
